// File: rtl/mips_loader_pkg.sv
// Shared definitions for the serial program loader.
//   - Frame geometry: HDR_BYTES (word-count header), WORD_BYTES (bytes per word)
//   - Loader FSM encoding (state_t)
//   - accepts_bytes(): states in which the loader accepts stream bytes
// Optional feature macro: LOADER_CHECKSUM_EN adds the CHECK state.
package mips_loader_pkg;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int BCNT_W     = $clog2(WORD_BYTES);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_HI = 3'd1,
        HDR_LO = 3'd2,
        DATA   = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        CHECK  = 3'd4,
`endif
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    function automatic logic accepts_bytes(input state_t s);
        case (s)
            HDR_HI, HDR_LO, DATA: return 1'b1;
`ifdef LOADER_CHECKSUM_EN
            CHECK:                return 1'b1;
`endif
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Packs stream bytes MSB-first into 32-bit words.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   clr            synchronous clear of word, byte counter and pulse
//   byte_en        byte_in is a payload byte to shift in this cycle
//   byte_in        payload byte
//   word           assembled word {b0,b1,b2,b3}; valid while word_done is high
//   word_done      one-cycle pulse in the cycle after the last byte of a word
module loader_word_assembler
    import mips_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_done
);

    logic [BCNT_W-1:0] bcnt;

    // A byte accepted during the word_done cycle shifts in at the closing
    // edge, so word still holds the complete word for the whole pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word      <= '0;
            bcnt      <= '0;
            word_done <= 1'b0;
        end else if (clr) begin
            word      <= '0;
            bcnt      <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= byte_en && (bcnt == BCNT_W'(WORD_BYTES - 1));
            if (byte_en) begin
                word <= {word[23:0], byte_in};
                bcnt <= bcnt + BCNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Serial program loader: receives a framed byte stream (2-byte word count N,
// then N big-endian 32-bit words) and writes the words into instruction
// memory while holding the CPU in reset.
// Ports:
//   CLK, RST               clock, asynchronous active-high reset
//   Load_Start             one-cycle load request (honoured in IDLE/DONE/ERR)
//   Byte_Data/Byte_Valid   incoming byte stream
//   Byte_Ready             loader accepts a byte this cycle
//   Mem_WE/Mem_Addr/Mem_WD instruction-memory write port
//   Cpu_Hold               CPU held in reset while high
//   Load_Done/Load_Error   outcome of the last load
// Optional feature macro: LOADER_CHECKSUM_EN -- one trailing byte, compared
// against the XOR of all payload bytes.
module program_loader
    import mips_loader_pkg::*;
#(
    parameter int          DEPTH     = 100,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Load_Start,
    input  logic [7:0]  Byte_Data,
    input  logic        Byte_Valid,
    output logic        Byte_Ready,
    output logic        Mem_WE,
    output logic [31:0] Mem_Addr,
    output logic [31:0] Mem_WD,
    output logic        Cpu_Hold,
    output logic        Load_Done,
    output logic        Load_Error
);

    state_t      state, state_nx;
    logic        xfer, start_ok, last_wr, payload_en;
    logic [7:0]  n_hi;
    logic [15:0] n_words, wcnt, hdr_n;
    logic [31:0] addr;

    assign hdr_n      = {n_hi, Byte_Data};
    assign Byte_Ready = accepts_bytes(state);
    assign xfer       = Byte_Valid & Byte_Ready;
    assign start_ok   = Load_Start && (state == IDLE || state == DONE || state == ERR);
    // Write cycle of the final word; the FSM leaves DATA at its closing edge,
    // so a byte accepted here is not payload.
    assign last_wr    = Mem_WE && (wcnt == n_words - 16'd1);
    assign payload_en = xfer && (state == DATA) && !last_wr;

    assign Cpu_Hold   = (state != IDLE) && (state != DONE);
    assign Load_Done  = (state == DONE);
    assign Load_Error = (state == ERR);
    assign Mem_Addr   = addr;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;
    logic       csum_ok;
    assign csum_ok = (Byte_Data == csum);
`endif

    loader_word_assembler u_asm (
        .clk       (CLK),
        .rst       (RST),
        .clr       (start_ok),
        .byte_en   (payload_en),
        .byte_in   (Byte_Data),
        .word      (Mem_WD),
        .word_done (Mem_WE)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            n_hi    <= '0;
            n_words <= '0;
            wcnt    <= '0;
            addr    <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
            csum    <= '0;
`endif
        end else begin
            state <= state_nx;
            if (xfer && state == HDR_HI) n_hi    <= Byte_Data;
            if (xfer && state == HDR_LO) n_words <= hdr_n;
            if (start_ok) begin
                wcnt <= '0;
                addr <= BASE_ADDR;
            end else if (Mem_WE) begin
                wcnt <= wcnt + 16'd1;
                addr <= addr + 32'd4;
            end
`ifdef LOADER_CHECKSUM_EN
            if (start_ok)        csum <= '0;
            else if (payload_en) csum <= csum ^ Byte_Data;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, ERR:
                if (Load_Start) state_nx = HDR_HI;
            HDR_HI:
                if (xfer) state_nx = HDR_LO;
            HDR_LO:
                if (xfer) begin
                    if (32'(hdr_n) > DEPTH) state_nx = ERR;
`ifdef LOADER_CHECKSUM_EN
                    else if (hdr_n == 16'd0) state_nx = CHECK;
`else
                    else if (hdr_n == 16'd0) state_nx = DONE;
`endif
                    else                     state_nx = DATA;
                end
            DATA:
                if (last_wr) begin
`ifdef LOADER_CHECKSUM_EN
                    // Checksum byte may already arrive in the final write cycle.
                    if (xfer) state_nx = csum_ok ? DONE : ERR;
                    else      state_nx = CHECK;
`else
                    state_nx = DONE;
`endif
                end
`ifdef LOADER_CHECKSUM_EN
            CHECK:
                if (xfer) state_nx = csum_ok ? DONE : ERR;
`endif
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    logic        CLK = 1'b0;
    logic        RST, Load_Start, Byte_Valid;
    logic [7:0]  Byte_Data;
    logic        Byte_Ready, Mem_WE, Cpu_Hold, Load_Done, Load_Error;
    logic [31:0] Mem_Addr, Mem_WD;

    int ncmp  = 0;
    int nfail = 0;

    logic [31:0] got_a[$], got_d[$], exp_a[$], exp_d[$];
    logic        prev_we = 1'b0;
    logic [7:0]  f[$];

    always #5 CLK = ~CLK;

    program_loader #(.DEPTH(100), .BASE_ADDR(32'h0000_0000)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Load_Start (Load_Start),
        .Byte_Data  (Byte_Data),
        .Byte_Valid (Byte_Valid),
        .Byte_Ready (Byte_Ready),
        .Mem_WE     (Mem_WE),
        .Mem_Addr   (Mem_Addr),
        .Mem_WD     (Mem_WD),
        .Cpu_Hold   (Cpu_Hold),
        .Load_Done  (Load_Done),
        .Load_Error (Load_Error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write monitor, sampled mid-cycle.
    always @(negedge CLK) begin
        if (Mem_WE === 1'b1) begin
            got_a.push_back(Mem_Addr);
            got_d.push_back(Mem_WD);
            chk("ready_during_we", {31'd0, Byte_Ready}, 32'd1);
            chk("we_single_cycle", {31'd0, prev_we}, 32'd0);
        end
        prev_we = Mem_WE;
    end

    task automatic pulse_start();
        Load_Start = 1'b1;
        Byte_Valid = 1'b1;
        Byte_Data  = 8'hFF;
        @(negedge CLK);
        chk("no_byte_with_start", {31'd0, Byte_Ready}, 32'd0);
        @(posedge CLK); #1;
        Load_Start = 1'b0;
        Byte_Valid = 1'b0;
        chk("hold_after_start", {31'd0, Cpu_Hold}, 32'd1);
    endtask

    task automatic send_frame(input logic [7:0] q[$], input bit gap);
        foreach (q[i]) begin
            int t;
            Byte_Data  = q[i];
            Byte_Valid = 1'b1;
            t = 0;
            @(negedge CLK);
            while (Byte_Ready !== 1'b1 && t < 50) begin
                @(negedge CLK);
                t++;
            end
            if (t >= 50) chk("byte_ready_timeout", {31'd0, Byte_Ready}, 32'd1);
            @(posedge CLK); #1;
            Byte_Valid = 1'b0;
            if (gap) begin
                @(posedge CLK); #1;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
        exp_a.push_back(a);
        exp_d.push_back(d);
    endtask

    task automatic check_wr(input string tag);
        chk({tag, "_count"}, got_a.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), got_a[i], exp_a[i]);
            chk($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
        end
        got_a.delete(); got_d.delete(); exp_a.delete(); exp_d.delete();
    endtask

    task automatic check_flags(input string tag, input logic done, input logic err, input logic hold);
        chk({tag, "_done"},  {31'd0, Load_Done},  {31'd0, done});
        chk({tag, "_error"}, {31'd0, Load_Error}, {31'd0, err});
        chk({tag, "_hold"},  {31'd0, Cpu_Hold},   {31'd0, hold});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; Load_Start = 1'b0; Byte_Valid = 1'b0; Byte_Data = 8'h00;
        #12;
        chk("rst_ready", {31'd0, Byte_Ready}, 32'd0);
        chk("rst_we",    {31'd0, Mem_WE},     32'd0);
        chk("rst_addr",  Mem_Addr,            32'd0);
        chk("rst_wd",    Mem_WD,              32'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        @(posedge CLK); #1;
        RST = 1'b0;
        idle_cycles(2);

        // Two words at full rate.
        pulse_start();
        f = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h04};
`ifdef LOADER_CHECKSUM_EN
        f.push_back(8'h8D);
`endif
        send_frame(f, 1'b0);
        idle_cycles(3);
        expect_wr(32'h0, 32'h2008_0005);
        expect_wr(32'h4, 32'hAC08_0004);
        check_wr("full_rate");
        check_flags("full_rate", 1'b1, 1'b0, 1'b0);

        // Oversized header: 101 words > DEPTH.
        pulse_start();
        f = '{8'h00, 8'h65};
        send_frame(f, 1'b0);
        idle_cycles(4);
        check_wr("oversize");
        check_flags("oversize", 1'b0, 1'b1, 1'b1);
        chk("oversize_ready", {31'd0, Byte_Ready}, 32'd0);

        // Three words with Byte_Valid toggling.
        pulse_start();
        f = '{8'h00, 8'h03, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h04,
              8'h01, 8'h02, 8'h03, 8'h04};
`ifdef LOADER_CHECKSUM_EN
        f.push_back(8'h89);
`endif
        send_frame(f, 1'b1);
        idle_cycles(3);
        expect_wr(32'h0, 32'h2008_0005);
        expect_wr(32'h4, 32'hAC08_0004);
        expect_wr(32'h8, 32'h0102_0304);
        check_wr("toggle");
        check_flags("toggle", 1'b1, 1'b0, 1'b0);

        // Load_Start mid-DATA is ignored.
        pulse_start();
        f = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08};
        send_frame(f, 1'b0);
        Load_Start = 1'b1;
        @(posedge CLK); #1;
        Load_Start = 1'b0;
        check_flags("midstart", 1'b0, 1'b0, 1'b1);
        f = '{8'h00, 8'h04};
`ifdef LOADER_CHECKSUM_EN
        f.push_back(8'h8D);
`endif
        send_frame(f, 1'b0);
        idle_cycles(3);
        expect_wr(32'h0, 32'h2008_0005);
        expect_wr(32'h4, 32'hAC08_0004);
        check_wr("midstart");
        check_flags("midstart_end", 1'b1, 1'b0, 1'b0);

        // Empty frame (N = 0).
        pulse_start();
        f = '{8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        f.push_back(8'h00);
`endif
        send_frame(f, 1'b0);
        idle_cycles(2);
        check_wr("empty");
        check_flags("empty", 1'b1, 1'b0, 1'b0);

        // Reset mid-load after two bytes of word 1.
        pulse_start();
        f = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08};
        send_frame(f, 1'b0);
        #2;
        RST = 1'b1;
        #1;
        chk("midrst_ready", {31'd0, Byte_Ready}, 32'd0);
        chk("midrst_we",    {31'd0, Mem_WE},     32'd0);
        chk("midrst_addr",  Mem_Addr,            32'd0);
        chk("midrst_wd",    Mem_WD,              32'd0);
        check_flags("midrst", 1'b0, 1'b0, 1'b0);
        expect_wr(32'h0, 32'h2008_0005);
        check_wr("pre_rst");
        @(posedge CLK); #1;
        RST = 1'b0;
        idle_cycles(1);
        pulse_start();
        f = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef LOADER_CHECKSUM_EN
        f.push_back(8'h44);
`endif
        send_frame(f, 1'b0);
        idle_cycles(3);
        expect_wr(32'h0, 32'h1122_3344);
        check_wr("post_rst");
        check_flags("post_rst", 1'b1, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum.
        pulse_start();
        f = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        send_frame(f, 1'b0);
        idle_cycles(3);
        expect_wr(32'h0, 32'h1122_3344);
        check_wr("bad_csum");
        check_flags("bad_csum", 1'b0, 1'b1, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
